// File: rtl/turbo_frame_pkg.sv
// Shared types and helpers for the turbo decoder frame assembler.
package turbo_frame_pkg;

    localparam int LLR_W = 32;

    typedef logic [LLR_W-1:0] llr_t;

    typedef enum logic {
        FILL   = 1'b0,
        RESYNC = 1'b1
    } wr_state_e;

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } buf_state_e;

    function automatic int streams(input int nout);
        return 1 + 2 * (nout - 1);
    endfunction

endpackage

// File: rtl/turbo_frame_buffer.sv
// One frame bank: symbol-indexed write port, whole-frame parallel read, FREE/FULL flag.
module turbo_frame_buffer
    import turbo_frame_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int STREAMS = 3,
    parameter int SYMBOLS = 66,
    parameter int IDX_W   = 7
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en_i,
    input  logic [IDX_W-1:0]                        wr_idx_i,
    input  logic [STREAMS-1:0][BITS-1:0]            wr_data_i,
    input  logic                                    set_full_i,
    input  logic                                    clr_i,
    output logic                                    full_o,
    output logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] rd_data_o
);

    logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] mem_q;
    buf_state_e                                state_q, state_d;

    // Payload storage carries no reset; only the FREE/FULL flag decides validity.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int s = 0; s < STREAMS; s++) begin
                mem_q[s][wr_idx_i] <= wr_data_i[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (set_full_i) begin
            state_d = FULL;
        end else if (clr_i) begin
            state_d = FREE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    assign full_o    = (state_q == FULL);
    assign rd_data_o = mem_q;

endmodule

// File: rtl/turbo_frame_assembler.sv
// Streams LLR symbols into a ping-pong pair of frame buffers and launches
// whole frames to the turbo decoder, with framing checks and launch holdoff.
module turbo_frame_assembler
    import turbo_frame_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int N         = 64,
    parameter int NOUT      = 2,
    parameter int TAIL_BITS = 2,
    parameter int STREAMS   = streams(NOUT),
    parameter int HOLDOFF   = 0,
    parameter int CNT_W     = 16
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             s_valid,
    output logic                                             s_ready,
    input  logic [STREAMS-1:0][BITS-1:0]                     s_llr,
    input  logic                                             s_last,
    input  logic                                             dec_busy,
    output logic                                             out_valid,
    output logic [STREAMS-1:0][N+TAIL_BITS-1:0][BITS-1:0]    y,
    output logic                                             len_err,
    output logic [CNT_W-1:0]                                 frames_out,
    output logic [CNT_W-1:0]                                 frames_dropped
);

    localparam int SYMBOLS = N + TAIL_BITS;
    localparam int IDX_W   = $clog2(SYMBOLS);
    localparam int HOLD_W  = 16;

    typedef logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] frame_t;

    wr_state_e         wstate_q, wstate_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  fout_q, fout_d;
    logic [CNT_W-1:0]  fdrop_q, fdrop_d;
    logic              out_valid_q, len_err_q;
    frame_t            y_q, y_d;

    logic [1:0]        buf_full;
    frame_t            buf_rd [2];
    logic              xfer, last_idx, wr_en, complete, err, launch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar b = 0; b < 2; b++) begin : g_buf
        turbo_frame_buffer #(
            .BITS    (BITS),
            .STREAMS (STREAMS),
            .SYMBOLS (SYMBOLS),
            .IDX_W   (IDX_W)
        ) u_buf (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (wr_en && (wsel_q == 1'(b))),
            .wr_idx_i   (widx_q),
            .wr_data_i  (s_llr),
            .set_full_i (complete && (wsel_q == 1'(b))),
            .clr_i      (launch && (rsel_q == 1'(b))),
            .full_o     (buf_full[b]),
            .rd_data_o  (buf_rd[b])
        );
    end

    // RESYNC swallows symbols regardless of buffer occupancy.
    assign s_ready  = (wstate_q == RESYNC) || !buf_full[wsel_q];
    assign xfer     = s_valid && s_ready;
    assign last_idx = (widx_q == IDX_W'(SYMBOLS - 1));
    assign launch   = buf_full[rsel_q] && !dec_busy && (hold_q == '0);

    always_comb begin
        wstate_d = wstate_q;
        widx_d   = widx_q;
        wsel_d   = wsel_q;
        wr_en    = 1'b0;
        complete = 1'b0;
        err      = 1'b0;
        if (xfer) begin
            unique case (wstate_q)
                FILL: begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        widx_d = '0;
                        if (last_idx) begin
                            complete = 1'b1;
                            wsel_d   = ~wsel_q;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (last_idx) begin
                        err      = 1'b1;
                        wstate_d = RESYNC;
                        widx_d   = '0;
                    end else begin
                        widx_d = widx_q + IDX_W'(1);
                    end
                end
                RESYNC: begin
                    if (s_last) begin
                        wstate_d = FILL;
                    end
                end
                default: wstate_d = FILL;
            endcase
        end
    end

    always_comb begin
        rsel_d  = rsel_q;
        y_d     = y_q;
        hold_d  = hold_q;
        fout_d  = fout_q;
        fdrop_d = err ? sat_inc(fdrop_q) : fdrop_q;
        if (launch) begin
            rsel_d = ~rsel_q;
            y_d    = buf_rd[rsel_q];
            hold_d = HOLD_W'(HOLDOFF);
            fout_d = sat_inc(fout_q);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q    <= FILL;
            widx_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            hold_q      <= '0;
            fout_q      <= '0;
            fdrop_q     <= '0;
            out_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            y_q         <= '0;
        end else begin
            wstate_q    <= wstate_d;
            widx_q      <= widx_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            hold_q      <= hold_d;
            fout_q      <= fout_d;
            fdrop_q     <= fdrop_d;
            out_valid_q <= launch;
            len_err_q   <= err;
            y_q         <= y_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign len_err        = len_err_q;
    assign y              = y_q;
    assign frames_out     = fout_q;
    assign frames_dropped = fdrop_q;

endmodule

// File: tb/tb_turbo_frame_assembler.sv
// Scoreboard bench for turbo_frame_assembler: frame-level reference model plus
// a second instance with a long launch holdoff.
module tb_turbo_frame_assembler;
    import turbo_frame_pkg::*;

    localparam int BITS    = 32;
    localparam int N       = 8;
    localparam int NOUT    = 2;
    localparam int TAIL    = 2;
    localparam int STREAMS = streams(NOUT);
    localparam int SYMBOLS = N + TAIL;
    localparam int CNT_W   = 16;
    localparam int HOLD_H  = 20;

    typedef logic [STREAMS-1:0][BITS-1:0]              sym_t;
    typedef logic [STREAMS-1:0][SYMBOLS-1:0][BITS-1:0] frame_t;

    logic clk, rst;
    logic s_valid, s_ready, s_last, dec_busy, out_valid, len_err;
    sym_t s_llr;
    frame_t y;
    logic [CNT_W-1:0] frames_out, frames_dropped;

    logic h_valid, h_ready, h_last, h_busy, h_out, h_err;
    sym_t h_llr;
    frame_t h_y;
    logic [CNT_W-1:0] h_fo, h_fd;

    turbo_frame_assembler #(.BITS(BITS), .N(N), .NOUT(NOUT), .TAIL_BITS(TAIL),
        .STREAMS(STREAMS), .HOLDOFF(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_llr(s_llr),
        .s_last(s_last), .dec_busy(dec_busy), .out_valid(out_valid), .y(y),
        .len_err(len_err), .frames_out(frames_out), .frames_dropped(frames_dropped));

    turbo_frame_assembler #(.BITS(BITS), .N(N), .NOUT(NOUT), .TAIL_BITS(TAIL),
        .STREAMS(STREAMS), .HOLDOFF(HOLD_H), .CNT_W(CNT_W)) dut_h (
        .clk(clk), .rst(rst), .s_valid(h_valid), .s_ready(h_ready), .s_llr(h_llr),
        .s_last(h_last), .dec_busy(h_busy), .out_valid(h_out), .y(h_y),
        .len_err(h_err), .frames_out(h_fo), .frames_dropped(h_fd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0, nfail = 0;
    int n_launch = 0, n_err = 0;

    // Reference model state: symbols of the frame being collected, and frames owed.
    sym_t   cur[$];
    bit     resync = 0;
    frame_t exp_q[$];
    int     mdl_frames = 0, mdl_drop = 0;
    int     last_edge = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    endtask

    task automatic abort_run(input string nm);
        ncmp++;
        nfail++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
        finish_run();
    endtask

    task automatic model_accept(input sym_t d, input bit last);
        frame_t f;
        if (resync) begin
            if (last) resync = 0;
            return;
        end
        cur.push_back(d);
        if (last) begin
            if (cur.size() == SYMBOLS) begin
                for (int i = 0; i < SYMBOLS; i++)
                    for (int k = 0; k < STREAMS; k++)
                        f[k][i] = cur[i][k];
                exp_q.push_back(f);
                mdl_frames++;
            end else begin
                mdl_drop++;
            end
            cur.delete();
        end else if (cur.size() == SYMBOLS) begin
            mdl_drop++;
            resync = 1;
            cur.delete();
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following the transfer.
    task automatic send_sym(input sym_t d, input bit last);
        int guard = 0;
        s_valid = 1'b1;
        s_llr   = d;
        s_last  = last;
        while (!s_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) abort_run("s_ready_wait");
        end
        model_accept(d, last);
        last_edge = cyc + 1;
        @(negedge clk);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int last_pos, input bit idx_data, input int gap_pct);
        sym_t d;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                idle();
                @(negedge clk);
            end
            for (int k = 0; k < STREAMS; k++)
                d[k] = idx_data ? BITS'(i) : BITS'($urandom);
            send_sym(d, i == last_pos);
        end
        idle();
    endtask

    task automatic drain(input string nm);
        int guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 500) abort_run(nm);
        end
        repeat (3) @(negedge clk);
        check({nm, "_frames_out"}, 64'(frames_out), 64'(mdl_frames));
        check({nm, "_frames_dropped"}, 64'(frames_dropped), 64'(mdl_drop));
    endtask

    task automatic send_h(input int base);
        int guard;
        for (int i = 0; i < SYMBOLS; i++) begin
            h_valid = 1'b1;
            h_last  = (i == SYMBOLS - 1);
            for (int k = 0; k < STREAMS; k++) h_llr[k] = BITS'(base + i);
            guard = 0;
            while (!h_ready) begin
                @(negedge clk);
                guard++;
                if (guard > 200) abort_run("h_ready_wait");
            end
            @(negedge clk);
        end
        h_valid = 1'b0;
        h_last  = 1'b0;
    endtask

    // Monitor: every launch must match the oldest frame the model owes.
    frame_t mon_e;
    int     ms, mi;
    always @(negedge clk) begin
        if (!rst) begin
            if (len_err) n_err++;
            if (out_valid) begin
                n_launch++;
                ncmp++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL launch_unexpected: out_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (y !== mon_e) begin
                        nfail++;
                        ms = 0;
                        mi = 0;
                        for (int s = 0; s < STREAMS; s++)
                            for (int i = 0; i < SYMBOLS; i++)
                                if (y[s][i] !== mon_e[s][i]) begin
                                    ms = s;
                                    mi = i;
                                end
                        $display("FAIL frame_data: y[%0d][%0d] got %0h expected %0h (cycle %0d)",
                                 ms, mi, y[ms][mi], mon_e[ms][mi], cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        abort_run("global_timeout");
    end

    bit tog_on;
    int t0, out_cyc, e0, l0, hp_cnt;
    int hp[$];

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_llr = '0; s_last = 1'b0; dec_busy = 1'b0;
        h_valid = 1'b0; h_llr = '0; h_last = 1'b0; h_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_y_nonzero", 64'(|y), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 1);
        check("rst_frames_out", 64'(frames_out), 0);
        check("rst_frames_dropped", 64'(frames_dropped), 0);
        check("rst_len_err", 64'(len_err), 0);

        // Single frame with index payload: latency and y layout.
        send_frame(SYMBOLS, SYMBOLS - 1, 1'b1, 0);
        out_cyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (out_valid) begin
                out_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("latency", 64'(out_cyc - last_edge), 1);
        check("frames_out_1", 64'(frames_out), 1);
        check("y_idx_s2_i7", 64'(y[2][7]), 7);
        check("y_idx_s0_i9", 64'(y[0][9]), 9);
        @(negedge clk);
        check("out_valid_one_cycle", 64'(out_valid), 0);
        drain("single");

        // Three back-to-back frames against a busy decoder.
        dec_busy = 1'b1;
        l0 = n_launch;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(SYMBOLS, SYMBOLS - 1, 1'b0, 0);
            end
            begin
                repeat (25) @(negedge clk);
                check("busy_s_ready_low", 64'(s_ready), 0);
                check("busy_no_launch", 64'(n_launch - l0), 0);
                repeat (15) @(negedge clk);
                dec_busy = 1'b0;
            end
        join
        drain("backlog");
        check("backlog_launches", 64'(n_launch - l0), 3);

        // Early last at index 5, then a good frame.
        e0 = n_err;
        send_frame(6, 5, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("early_len_err", 64'(n_err - e0), 1);
        check("early_dropped", 64'(frames_dropped), 1);
        send_frame(SYMBOLS, SYMBOLS - 1, 1'b0, 0);
        drain("early");

        // Missing last, four resync symbols, then a good frame.
        e0 = n_err;
        send_frame(SYMBOLS, -1, 1'b0, 0);
        send_frame(4, 3, 1'b0, 0);
        send_frame(SYMBOLS, SYMBOLS - 1, 1'b0, 0);
        drain("resync");
        check("resync_len_err", 64'(n_err - e0), 1);

        // Randomised traffic: mixed frame shapes, gaps and decoder backpressure.
        e0 = n_err;
        l0 = mdl_drop;
        tog_on = 1;
        fork
            begin
                for (int f = 0; f < 14; f++) begin
                    int kind, len;
                    kind = $urandom_range(9);
                    if (kind < 7) begin
                        send_frame(SYMBOLS, SYMBOLS - 1, 1'b0, 20);
                    end else if (kind == 7) begin
                        len = $urandom_range(SYMBOLS - 1, 1);
                        send_frame(len, len - 1, 1'b0, 20);
                    end else begin
                        send_frame(SYMBOLS, -1, 1'b0, 20);
                        len = $urandom_range(4, 1);
                        send_frame(len, len - 1, 1'b0, 20);
                    end
                end
                tog_on = 0;
            end
            begin
                while (tog_on) begin
                    @(negedge clk);
                    dec_busy = ($urandom_range(3) == 0);
                end
                dec_busy = 1'b0;
            end
        join
        drain("random");
        check("random_len_err", 64'(n_err - e0), 64'(mdl_drop - l0));

        // Reset mid-frame with a full buffer pending.
        dec_busy = 1'b1;
        send_frame(SYMBOLS, SYMBOLS - 1, 1'b0, 0);
        send_frame(4, -1, 1'b0, 0);
        s_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 0);
        check("arst_y_nonzero", 64'(|y), 0);
        check("arst_frames_out", 64'(frames_out), 0);
        check("arst_frames_dropped", 64'(frames_dropped), 0);
        exp_q.delete();
        cur.delete();
        resync = 0;
        mdl_frames = 0;
        mdl_drop = 0;
        idle();
        @(negedge clk);
        rst = 1'b0;
        dec_busy = 1'b0;
        l0 = n_launch;
        repeat (10) @(negedge clk);
        check("arst_no_launch", 64'(n_launch - l0), 0);
        send_frame(SYMBOLS, SYMBOLS - 1, 1'b0, 0);
        drain("after_reset");

        // Holdoff instance: two queued frames launch HOLDOFF+1 cycles apart.
        h_busy = 1'b1;
        send_h(0);
        send_h(16);
        @(negedge clk);
        check("h_ready_both_full", 64'(h_ready), 0);
        h_busy = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (h_out) hp.push_back(cyc);
        end
        hp_cnt = hp.size();
        check("h_pulse_count", 64'(hp_cnt), 2);
        if (hp_cnt >= 2) check("h_spacing", 64'(hp[1] - hp[0]), HOLD_H + 1);
        check("h_frames_out", 64'(h_fo), 2);
        check("h_y_second", 64'(h_y[1][3]), 16 + 3);
        check("h_dropped", 64'(h_fd), 0);
        check("h_len_err", 64'(h_err), 0);

        finish_run();
    end

endmodule

// File: doc/turbo_frame_assembler.md
Name: turbo_frame_assembler

Overview:
- Streaming front end for turbo_decode. Accepts channel LLR symbols one per cycle (all streams in parallel) over a valid/ready handshake.
- Assembles complete frames of N+TAIL_BITS symbols in a ping-pong buffer pair.
- Launches each frame to the decoder as a one-cycle out_valid with a full parallel y array, throttled by decoder busy and a programmable holdoff.
- Generalises the single-shot in_valid/y drive to continuous traffic with framing checks.

Parameters:
- BITS, 32, LLR word width (raw bits; shortreal encoding when 32).
- N, 64, information bits per frame.
- NOUT, 2, encoder outputs per constituent code.
- TAIL_BITS, 2, tail symbols per frame.
- STREAMS, 1+2*(NOUT-1), LLR streams per symbol (systematic + parities).
- HOLDOFF, 0, minimum idle cycles between consecutive out_valid pulses (0..65535).
- CNT_W, 16, width of statistics counters.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- s_valid, input, 1, input symbol valid.
- s_ready, output, 1, assembler can accept a symbol.
- s_llr, input, [STREAMS][BITS], one symbol: LLRs for all streams.
- s_last, input, 1, marks the final symbol of a frame.
- dec_busy, input, 1, decoder cannot take a frame.
- out_valid, output, 1, one-cycle frame launch (drives turbo_decode in_valid).
- y, output, [STREAMS][N+TAIL_BITS][BITS], launched frame (drives turbo_decode y).
- len_err, output, 1, one-cycle pulse on a framing error.
- frames_out, output, CNT_W, frames launched, saturating.
- frames_dropped, output, CNT_W, frames discarded, saturating.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values:
  - out_valid=0, y all zero, len_err=0, counters 0.
  - Both buffers FREE, write select 0, write index 0, write FSM FILL, holdoff counter 0.
  - s_ready=1 once rst deasserts.
  - Reset mid-frame discards all partial and full buffers.
- Transfer occurs on a clock edge with s_valid && s_ready.
- s_ready depends only on registered state: it is 1 iff the write buffer is FREE and the write FSM is FILL. The one exception is RESYNC, where s_ready=1 and symbols are consumed and dropped.
- Write FSM, FILL state (per transfer, index i):
  - Store s_llr at y-position i.
  - If s_last && i==SYMBOLS-1: mark buffer FULL, toggle write select, i=0.
  - If s_last && i<SYMBOLS-1: early last. Pulse len_err, frames_dropped++, i=0, buffer stays FREE.
  - If !s_last && i==SYMBOLS-1: missing last. Pulse len_err, frames_dropped++, go to RESYNC.
  - Otherwise i++.
- Write FSM, RESYNC state: drop transfers until one with s_last, then go to FILL with i=0.
- Launch control:
  - Buffers launch in fill order (oldest FULL first; a one-bit read select tracks this).
  - A launch occurs in any cycle where the read buffer is FULL, dec_busy=0 and holdoff counter==0.
  - On the following edge: y is loaded from the read buffer, out_valid=1 for exactly that cycle, the buffer becomes FREE, read select toggles, holdoff counter loads HOLDOFF, frames_out++.
- y holds its value until the next launch.
- Holdoff counter decrements to 0 while nonzero.
- Latency: last symbol accepted on edge E gives earliest out_valid in the cycle after edge E+1 (2 cycles).
- Simultaneous events:
  - Frame completion into one buffer and launch from the other on the same edge are both honoured.
  - A buffer freed by a launch on edge E is writable (s_ready=1) from the cycle after E.
- Both buffers FULL ⇒ s_ready=0 until a launch.
- Counters saturate at 2^CNT_W-1.

Decomposition:
- Package turbo_frame_pkg holds:
  - streams(NOUT) constant function.
  - llr_t typedef logic [BITS-1:0].
  - write-FSM enum {FILL, RESYNC}.
  - Buffer state enum {FREE, FULL}.
- Sub-module turbo_frame_buffer: one bank with indexed write, full-frame parallel read, and FREE/FULL flag. Instantiated twice.

Test Plan (N=8, TAIL_BITS=2, SYMBOLS=10, STREAMS=3, HOLDOFF=0 unless stated):
- Single frame, s_valid continuous, s_llr[k]=symbol index, s_last on index 9, dec_busy=0 → out_valid one cycle exactly 2 cycles after last transfer; y[k][i]==i for all k; frames_out=1.
- Three back-to-back frames with dec_busy=1 for 40 cycles:
  - s_ready drops after frame 2 and frame 3 stalls.
  - On release, frames launch in order 1, 2, then 3; frames_out=3, no data loss.
- s_last on index 5 → len_err pulse, frames_dropped=1, no out_valid; the next well-formed frame launches correctly.
- No s_last at index 9, then 4 extra symbols with s_last on the 4th → len_err once, RESYNC drops those symbols; the following frame launches with correct data.
- HOLDOFF=20, two frames ready → out_valid pulses exactly 21 cycles apart.
- rst asserted mid-frame (index 4) with one FULL buffer pending → outputs and counters zero immediately, no launch afterwards; the next full frame launches normally.
